ball_renderer: RTL and testbench
================================

# ball_renderer

Pixel-colour stage directly downstream of the VGA sync/counter generator. It consumes the horizontal counter, vertical counter and display-area flag, and produces registered 1-bit R/G/B outputs. The picture is a white 1-pixel screen border plus a square ball that moves once per frame and bounces off the visible edges. The ball's colour advances on every bounce.

## Interface

Parameters:
- BALL_SIZE, 16: ball edge length in pixels.
- STEP, 2: pixels moved per axis per frame (1..BALL_SIZE).
- INIT_X, 320: ball left edge after reset (0..640-BALL_SIZE).
- INIT_Y, 240: ball top edge after reset (0..480-BALL_SIZE).

Ports:
- clk  in  1  pixel clock, shared with the sync generator; all logic on posedge.
- reset  in  1  synchronous, active-high.
- CounterX  in  10  horizontal counter; counts 0..767 and wraps.
- CounterY  in  9  vertical counter; increments when CounterX==767 and wraps 511→0.
- inDisplayArea  in  1  high during visible pixels (640×480).
- pause  in  1  when high at a frame tick, freezes motion and colour.
- vga_R, vga_G, vga_B  out  1 each  registered pixel colour.

## Operation

- State registers:
  - ball_x[9:0], ball_y[8:0] (top-left corner).
  - dx, dy: 1 = increasing, 0 = decreasing.
  - colour[2:0] as {R,G,B}.
- Reset values: ball_x=INIT_X, ball_y=INIT_Y, dx=1, dy=1, colour=3'b100 (red), vga_R/G/B=0.
- Frame tick: asserted for the single cycle where CounterX==767 and CounterY==479 (end of the last visible line).
  - Position and colour update only on this cycle, so the ball never tears mid-frame.
- Limits: XMAX = 640-BALL_SIZE (624 at default), YMAX = 480-BALL_SIZE (464 at default). All sums use 11-bit arithmetic; no wrap-around.
- X axis on a tick with pause=0 (Y axis is identical with ball_y, dy, YMAX):
  - dx=1 and ball_x+STEP ≥ XMAX: ball_x←XMAX, dx←0, bounce.
  - dx=1 otherwise: ball_x←ball_x+STEP.
  - dx=0 and ball_x ≤ STEP: ball_x←0, dx←1, bounce.
  - dx=0 otherwise: ball_x←ball_x−STEP.
- Colour: if either axis bounces on a tick, colour←colour+1 once, skipping 000 (111→001).
  - A simultaneous X and Y bounce (corner) still increments colour only once.
- Pause: a tick with pause=1 changes nothing. pause is ignored on non-tick cycles.
- Pixel priority, evaluated on the current CounterX/CounterY:
  1. inDisplayArea=0 → 000.
  2. Ball hit (ball_x ≤ CounterX < ball_x+BALL_SIZE and ball_y ≤ CounterY < ball_y+BALL_SIZE) → colour.
  3. Border (CounterX==0, CounterX==639, CounterY==0 or CounterY==479) → 111.
  4. Otherwise → 000.
- Reset asserted mid-frame: state returns to reset values on the next edge and outputs go 0. Motion resumes at the next frame tick after release.

## Timing

- vga_R/G/B are registered: the output for counter values sampled at edge n appears after edge n (1-cycle latency). This matches the registered sync outputs of the sync generator, so pixels and syncs stay aligned.
- State update: registers change on the edge that samples the frame tick. The new position is visible from the first pixel of the next frame (CounterY=0).
- No handshakes. The block is always ready, and throughput is one pixel per clock.

## Test plan

- Reset, defaults: hold reset 3 cycles then release. Outputs are 000. Across the first full frame, the ball is drawn red at x 320..335, y 240..255. After the first tick, ball_x=322 and ball_y=242.
- Right/bottom wall, defaults: run 112 ticks. ball_y clamps at 464, dy=0, colour 100→101. Continue to tick 152: ball_x=624, dx=0, colour→110.
- Corner, INIT_X=160, INIT_Y=0: run 232 ticks. Both axes bounce on the same tick (624, 464). dx=dy=0 and colour increments exactly once, 100→101.
- Colour wrap: preload colour to 111 via a parameterised start, or run 3 further bounces from 101 through 110 and 111. The next bounce gives 001, never 000.
- Pause: hold pause=1 across 5 ticks. Position and colour are unchanged. Release pause; the next tick moves the ball by STEP.
- Gating and latency:
  - With inDisplayArea=0 for a ball-covered coordinate, the output is 000.
  - Pixel (0,100) outputs 111 one cycle after it is presented.
  - Pixel (639,479) also outputs 111, one cycle later.

Source files
------------

// File: rtl/ball_renderer_if.sv
// Purpose: pixel-stage bundle between the VGA counter generator and the ball renderer.
// Latency: none, wires only.
// Backpressure: none; one pixel per clock, the renderer is always ready.
interface ball_renderer_if;
    logic [9:0] CounterX;
    logic [8:0] CounterY;
    logic       inDisplayArea;
    logic       pause;
    logic       vga_R;
    logic       vga_G;
    logic       vga_B;

    // Counter generator side: drives the raster position, receives the pixel colour.
    modport master (
        output CounterX,
        output CounterY,
        output inDisplayArea,
        output pause,
        input  vga_R,
        input  vga_G,
        input  vga_B
    );

    // Renderer side: consumes the raster position, drives the pixel colour.
    modport slave (
        input  CounterX,
        input  CounterY,
        input  inDisplayArea,
        input  pause,
        output vga_R,
        output vga_G,
        output vga_B
    );
endinterface

// File: rtl/ball_renderer.sv
// Purpose: draws a 1-pixel white border plus a bouncing square ball that recolours on every bounce.
// Latency: 1 clock from CounterX/CounterY/inDisplayArea to vga_R/G/B.
// Backpressure: none; always ready, one pixel per clock.
module ball_renderer #(
    parameter int BALL_SIZE = 16,
    parameter int STEP      = 2,
    parameter int INIT_X    = 320,
    parameter int INIT_Y    = 240
) (
    input  logic            clk,
    input  logic            reset,
    ball_renderer_if.slave  vga
);

    // Travel limits for the top-left corner; all position maths is done in
    // 11 bits so a step past the right/bottom edge can never wrap.
    localparam logic [10:0] XMAX   = 11'(640 - BALL_SIZE);
    localparam logic [10:0] YMAX   = 11'(480 - BALL_SIZE);
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [10:0] SIZE11 = 11'(BALL_SIZE);

    localparam logic [9:0]  LAST_X     = 10'd767;
    localparam logic [8:0]  LAST_VIS_Y = 9'd479;
    localparam logic [9:0]  RIGHT_X    = 10'd639;

    // Ball state.
    logic [9:0] ballX;
    logic [8:0] ballY;
    logic       dx;
    logic       dy;
    logic [2:0] colour;

    // Next-state candidates, committed only on an unpaused frame tick.
    logic [9:0] nextX;
    logic [8:0] nextY;
    logic       nextDx;
    logic       nextDy;
    logic [2:0] nextColour;
    logic       bounceX;
    logic       bounceY;

    logic        frameTick;
    logic [10:0] sumX;
    logic [10:0] sumY;
    logic [10:0] curX;
    logic [10:0] curY;
    logic [10:0] ballX11;
    logic [10:0] ballY11;

    logic       ballHit;
    logic       border;
    logic [2:0] pixel;
    logic [2:0] rgbQ;

    // The tick sits at the end of the last visible line, so every position
    // change lands in blanking and the ball never tears within a frame.
    assign frameTick = (vga.CounterX == LAST_X) && (vga.CounterY == LAST_VIS_Y);

    assign ballX11 = {1'b0, ballX};
    assign ballY11 = {2'b0, ballY};
    assign sumX    = ballX11 + STEP11;
    assign sumY    = ballY11 + STEP11;
    assign curX    = {1'b0, vga.CounterX};
    assign curY    = {2'b0, vga.CounterY};

    // Horizontal motion: clamp to the wall and reverse when the next step would reach it.
    always_comb begin
        nextX   = ballX;
        nextDx  = dx;
        bounceX = 1'b0;
        if (dx) begin
            if (sumX >= XMAX) begin
                nextX   = XMAX[9:0];
                nextDx  = 1'b0;
                bounceX = 1'b1;
            end else begin
                nextX = sumX[9:0];
            end
        end else begin
            if (ballX11 <= STEP11) begin
                nextX   = 10'd0;
                nextDx  = 1'b1;
                bounceX = 1'b1;
            end else begin
                nextX = ballX - STEP11[9:0];
            end
        end
    end

    // Vertical motion: same rule as horizontal, against the top/bottom walls.
    always_comb begin
        nextY   = ballY;
        nextDy  = dy;
        bounceY = 1'b0;
        if (dy) begin
            if (sumY >= YMAX) begin
                nextY   = YMAX[8:0];
                nextDy  = 1'b0;
                bounceY = 1'b1;
            end else begin
                nextY = sumY[8:0];
            end
        end else begin
            if (ballY11 <= STEP11) begin
                nextY   = 9'd0;
                nextDy  = 1'b1;
                bounceY = 1'b1;
            end else begin
                nextY = ballY - STEP11[8:0];
            end
        end
    end

    // Colour steps once per bouncing tick (a corner counts once) and skips black.
    always_comb begin
        nextColour = colour;
        if (bounceX || bounceY) begin
            if (colour == 3'b111) begin
                nextColour = 3'b001;
            end else begin
                nextColour = colour + 3'd1;
            end
        end
    end

    // Pixel colour for the current raster position: blanking, then ball, then border.
    always_comb begin
        ballHit = (curX >= ballX11) && (curX < ballX11 + SIZE11) &&
                  (curY >= ballY11) && (curY < ballY11 + SIZE11);
        border  = (vga.CounterX == 10'd0) || (vga.CounterX == RIGHT_X) ||
                  (vga.CounterY == 9'd0)  || (vga.CounterY == LAST_VIS_Y);
        pixel   = 3'b000;
        if (!vga.inDisplayArea) begin
            pixel = 3'b000;
        end else if (ballHit) begin
            pixel = colour;
        end else if (border) begin
            pixel = 3'b111;
        end
    end

    // Ball state advances only on an unpaused frame tick; pixel output is registered every clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            ballX  <= 10'(INIT_X);
            ballY  <= 9'(INIT_Y);
            dx     <= 1'b1;
            dy     <= 1'b1;
            colour <= 3'b100;
            rgbQ   <= 3'b000;
        end else begin
            if (frameTick && !vga.pause) begin
                ballX  <= nextX;
                ballY  <= nextY;
                dx     <= nextDx;
                dy     <= nextDy;
                colour <= nextColour;
            end
            rgbQ <= pixel;
        end
    end

    assign vga.vga_R = rgbQ[2];
    assign vga.vga_G = rgbQ[1];
    assign vga.vga_B = rgbQ[0];

endmodule

// File: tb/tb_ball_renderer.sv
// Purpose: directed check of ball_renderer drawing, motion, bounces, pause and reset.
// Latency: expects pixel colour one clock after the raster position is presented.
// Backpressure: none; the bench drives one raster position per clock.
module tb_ball_renderer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ball_renderer_if va();
    ball_renderer_if vb();

    // The corner-case instance shares the raster stimulus of the default instance.
    assign vb.CounterX      = va.CounterX;
    assign vb.CounterY      = va.CounterY;
    assign vb.inDisplayArea = va.inDisplayArea;
    assign vb.pause         = va.pause;

    ball_renderer #(.BALL_SIZE(16), .STEP(2), .INIT_X(320), .INIT_Y(240)) dutA (
        .clk   (clk),
        .reset (reset),
        .vga   (va)
    );

    ball_renderer #(.BALL_SIZE(16), .STEP(2), .INIT_X(160), .INIT_Y(0)) dutB (
        .clk   (clk),
        .reset (reset),
        .vga   (vb)
    );

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic       de;
        logic [2:0] expA;
        logic       chkB;
        logic [2:0] expB;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   nTests = 0;
    int   nFail  = 0;
    int   nMoves = 0;

    function automatic logic [2:0] rgbA();
        return {va.vga_R, va.vga_G, va.vga_B};
    endfunction

    function automatic logic [2:0] rgbB();
        return {vb.vga_R, vb.vga_G, vb.vga_B};
    endfunction

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic cycle(input logic [9:0] x, input logic [8:0] y, input logic de, input logic p);
        @(negedge clk);
        va.CounterX      = x;
        va.CounterY      = y;
        va.inDisplayArea = de;
        va.pause         = p;
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string name, input logic [9:0] x, input logic [8:0] y,
                         input logic de, input logic [2:0] expA,
                         input logic chkB, input logic [2:0] expB);
        cycle(x, y, de, 1'b0);
        check3({name, "/A"}, rgbA(), expA);
        if (chkB) begin
            check3({name, "/B"}, rgbB(), expB);
        end
    endtask

    // Each tick is one cycle at the end of the last visible line followed by an idle cycle.
    task automatic ticks(input int n, input logic p);
        for (int i = 0; i < n; i++) begin
            cycle(10'd767, 9'd479, 1'b0, p);
            cycle(10'd0, 9'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic runTo(input int target);
        ticks(target - nMoves, 1'b0);
        nMoves = target;
    endtask

    function automatic void addVec(input logic [9:0] x, input logic [8:0] y, input logic de,
                                   input logic [2:0] expA, input logic chkB,
                                   input logic [2:0] expB, input string name);
        vec_t v;
        v.x = x; v.y = y; v.de = de; v.expA = expA; v.chkB = chkB; v.expB = expB; v.name = name;
        vecs.push_back(v);
    endfunction

    initial begin
        // A: ball at (320..335, 240..255) red.  B: ball at (160..175, 0..15) red.
        addVec(10'd100, 9'd100, 1'b1, 3'b000, 1'b1, 3'b000, "blank");
        addVec(10'd320, 9'd240, 1'b1, 3'b100, 1'b1, 3'b000, "ball_tl");
        addVec(10'd335, 9'd255, 1'b1, 3'b100, 1'b1, 3'b000, "ball_br");
        addVec(10'd336, 9'd240, 1'b1, 3'b000, 1'b1, 3'b000, "right_of_ball");
        addVec(10'd320, 9'd256, 1'b1, 3'b000, 1'b1, 3'b000, "below_ball");
        addVec(10'd319, 9'd240, 1'b1, 3'b000, 1'b1, 3'b000, "left_of_ball");
        addVec(10'd320, 9'd240, 1'b0, 3'b000, 1'b1, 3'b000, "ball_gated");
        addVec(10'd0,   9'd100, 1'b1, 3'b111, 1'b1, 3'b111, "border_left");
        addVec(10'd639, 9'd100, 1'b1, 3'b111, 1'b1, 3'b111, "border_right");
        addVec(10'd638, 9'd100, 1'b1, 3'b000, 1'b1, 3'b000, "inside_right");
        addVec(10'd100, 9'd479, 1'b1, 3'b111, 1'b1, 3'b111, "border_bottom");
        addVec(10'd160, 9'd0,   1'b1, 3'b111, 1'b1, 3'b100, "ball_over_border");
        addVec(10'd176, 9'd0,   1'b1, 3'b111, 1'b1, 3'b111, "top_border");
        addVec(10'd167, 9'd15,  1'b1, 3'b000, 1'b1, 3'b100, "b_ball_bottom");
        addVec(10'd167, 9'd16,  1'b1, 3'b000, 1'b1, 3'b000, "b_below_ball");
        addVec(10'd0,   9'd0,   1'b0, 3'b000, 1'b1, 3'b000, "corner_gated");

        // Reset held three cycles with a ball pixel presented: outputs stay black.
        reset            = 1'b1;
        va.CounterX      = 10'd320;
        va.CounterY      = 9'd240;
        va.inDisplayArea = 1'b1;
        va.pause         = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(10'd320, 9'd240, 1'b1, 1'b0);
            check3("reset_out/A", rgbA(), 3'b000);
            check3("reset_out/B", rgbB(), 3'b000);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            probe(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].de,
                  vecs[i].expA, vecs[i].chkB, vecs[i].expB);
        end

        // Latency: border pixel is not visible before the edge, appears after it.
        probe("lat_pre", 10'd100, 9'd100, 1'b1, 3'b000, 1'b0, 3'b000);
        @(negedge clk);
        va.CounterX = 10'd0; va.CounterY = 9'd100; va.inDisplayArea = 1'b1;
        #1;
        check3("lat_before_edge", rgbA(), 3'b000);
        @(posedge clk);
        #1;
        check3("lat_border_0_100", rgbA(), 3'b111);
        probe("lat_border_639_479", 10'd639, 9'd479, 1'b1, 3'b111, 1'b0, 3'b000);
        probe("lat_after", 10'd100, 9'd100, 1'b1, 3'b000, 1'b0, 3'b000);

        // First move.
        runTo(1);
        probe("m1_tl",    10'd322, 9'd242, 1'b1, 3'b100, 1'b0, 3'b000);
        probe("m1_left",  10'd321, 9'd242, 1'b1, 3'b000, 1'b0, 3'b000);
        probe("m1_br",    10'd337, 9'd257, 1'b1, 3'b100, 1'b0, 3'b000);
        probe("m1_right", 10'd338, 9'd242, 1'b1, 3'b000, 1'b0, 3'b000);
        probe("m1_above", 10'd322, 9'd241, 1'b1, 3'b000, 1'b0, 3'b000);
        probe("m1_b_tl",  10'd162, 9'd2,   1'b1, 3'b000, 1'b1, 3'b100);
        probe("m1_b_left",10'd161, 9'd2,   1'b1, 3'b000, 1'b1, 3'b000);

        // Pause across five ticks: nothing moves.
        ticks(5, 1'b1);
        probe("pause_tl",   10'd322, 9'd242, 1'b1, 3'b100, 1'b0, 3'b000);
        probe("pause_left", 10'd321, 9'd242, 1'b1, 3'b000, 1'b0, 3'b000);
        probe("pause_b",    10'd162, 9'd2,   1'b1, 3'b000, 1'b1, 3'b100);
        runTo(2);
        probe("unpause_tl",   10'd324, 9'd244, 1'b1, 3'b100, 1'b0, 3'b000);
        probe("unpause_left", 10'd323, 9'd244, 1'b1, 3'b000, 1'b0, 3'b000);
        probe("unpause_b",    10'd164, 9'd4,   1'b1, 3'b000, 1'b1, 3'b100);

        // Bottom wall: y 462 -> 464 on move 112, colour 100 -> 101.
        runTo(111);
        probe("m111_tl",   10'd542, 9'd462, 1'b1, 3'b100, 1'b0, 3'b000);
        probe("m111_bot",  10'd542, 9'd477, 1'b1, 3'b100, 1'b0, 3'b000);
        probe("m111_below",10'd542, 9'd478, 1'b1, 3'b000, 1'b0, 3'b000);
        runTo(112);
        probe("m112_tl",    10'd544, 9'd464, 1'b1, 3'b101, 1'b0, 3'b000);
        probe("m112_onbrd", 10'd544, 9'd479, 1'b1, 3'b101, 1'b0, 3'b000);
        probe("m112_above", 10'd544, 9'd463, 1'b1, 3'b000, 1'b0, 3'b000);
        probe("m112_right", 10'd560, 9'd464, 1'b1, 3'b000, 1'b0, 3'b000);
        runTo(113);
        probe("m113_tl",   10'd546, 9'd462, 1'b1, 3'b101, 1'b0, 3'b000);
        probe("m113_below",10'd546, 9'd478, 1'b1, 3'b000, 1'b0, 3'b000);

        // Right wall on move 152, colour 101 -> 110.
        runTo(152);
        probe("m152_tl",    10'd624, 9'd384, 1'b1, 3'b110, 1'b0, 3'b000);
        probe("m152_onbrd", 10'd639, 9'd384, 1'b1, 3'b110, 1'b0, 3'b000);
        probe("m152_left",  10'd623, 9'd384, 1'b1, 3'b000, 1'b0, 3'b000);
        runTo(153);
        probe("m153_tl",    10'd622, 9'd382, 1'b1, 3'b110, 1'b0, 3'b000);
        probe("m153_br",    10'd637, 9'd397, 1'b1, 3'b110, 1'b0, 3'b000);
        probe("m153_right", 10'd638, 9'd382, 1'b1, 3'b000, 1'b0, 3'b000);

        // Corner on instance B at move 232: both axes bounce, colour steps once.
        runTo(231);
        probe("c231_tl",   10'd622, 9'd462, 1'b1, 3'b000, 1'b1, 3'b100);
        probe("c231_left", 10'd621, 9'd462, 1'b1, 3'b000, 1'b1, 3'b000);
        runTo(232);
        probe("c232_tl",     10'd624, 9'd464, 1'b1, 3'b000, 1'b1, 3'b101);
        probe("c232_corner", 10'd639, 9'd479, 1'b1, 3'b111, 1'b1, 3'b101);
        probe("c232_out",    10'd623, 9'd463, 1'b1, 3'b000, 1'b1, 3'b000);
        probe("m232_a",      10'd464, 9'd224, 1'b1, 3'b110, 1'b0, 3'b000);
        runTo(233);
        probe("c233_tl",  10'd622, 9'd462, 1'b1, 3'b000, 1'b1, 3'b101);
        probe("c233_br",  10'd637, 9'd477, 1'b1, 3'b000, 1'b1, 3'b101);
        probe("c233_out", 10'd638, 9'd478, 1'b1, 3'b000, 1'b1, 3'b000);

        // Top wall on move 344, colour 110 -> 111.
        runTo(343);
        probe("m343_tl",    10'd242, 9'd2, 1'b1, 3'b110, 1'b0, 3'b000);
        probe("m343_above", 10'd242, 9'd1, 1'b1, 3'b000, 1'b0, 3'b000);
        runTo(344);
        probe("m344_br",    10'd255, 9'd15, 1'b1, 3'b111, 1'b0, 3'b000);
        probe("m344_below", 10'd240, 9'd16, 1'b1, 3'b000, 1'b0, 3'b000);
        probe("m344_left",  10'd239, 9'd5,  1'b1, 3'b000, 1'b0, 3'b000);

        // Left wall on move 464, colour wraps 111 -> 001.
        runTo(463);
        probe("m463_tl",   10'd2,  9'd238, 1'b1, 3'b111, 1'b0, 3'b000);
        probe("m463_br",   10'd17, 9'd253, 1'b1, 3'b111, 1'b0, 3'b000);
        probe("m463_left", 10'd1,  9'd238, 1'b1, 3'b000, 1'b0, 3'b000);
        runTo(464);
        probe("wrap_tl",    10'd0,  9'd240, 1'b1, 3'b001, 1'b0, 3'b000);
        probe("wrap_br",    10'd15, 9'd255, 1'b1, 3'b001, 1'b0, 3'b000);
        probe("wrap_right", 10'd16, 9'd240, 1'b1, 3'b000, 1'b0, 3'b000);
        probe("wrap_brd",   10'd0,  9'd239, 1'b1, 3'b111, 1'b0, 3'b000);
        runTo(465);
        probe("m465_tl",   10'd2, 9'd242, 1'b1, 3'b001, 1'b0, 3'b000);
        probe("m465_left", 10'd1, 9'd242, 1'b1, 3'b000, 1'b0, 3'b000);

        // Mid-frame reset on a lit pixel: output drops, state returns to defaults.
        @(negedge clk);
        reset = 1'b1;
        cycle(10'd2, 9'd242, 1'b1, 1'b0);
        check3("midreset/A", rgbA(), 3'b000);
        check3("midreset/B", rgbB(), 3'b000);
        @(negedge clk);
        reset = 1'b0;
        probe("rst_ball",   10'd320, 9'd240, 1'b1, 3'b100, 1'b0, 3'b000);
        probe("rst_b_ball", 10'd160, 9'd0,   1'b1, 3'b111, 1'b1, 3'b100);
        probe("rst_old",    10'd2,   9'd242, 1'b1, 3'b000, 1'b0, 3'b000);
        ticks(1, 1'b0);
        probe("rst_move_tl",   10'd322, 9'd242, 1'b1, 3'b100, 1'b0, 3'b000);
        probe("rst_move_left", 10'd321, 9'd242, 1'b1, 3'b000, 1'b0, 3'b000);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
